// File: rtl/multi_drive_ctrl_if.sv
// Shared Shugart-style FDC bus: host-side controls in, active-low status and debug track out.
// master = FDC/host side, slave = drive controller.
interface multi_drive_ctrl_if #(
   parameter int NUM_DRIVES = 2
);
   logic [NUM_DRIVES-1:0] drive_sel;
   logic                  motor_on;
   logic                  dir_sel;
   logic                  step;
   logic                  dens_sel;
   logic                  index;
   logic                  track_0;
   logic                  wr_protect;
   logic                  ready;
   logic [6:0]            cur_track;

   modport master (
      output drive_sel, motor_on, dir_sel, step, dens_sel,
      input  index, track_0, wr_protect, ready, cur_track
   );

   modport slave (
      input  drive_sel, motor_on, dir_sel, step, dens_sel,
      output index, track_0, wr_protect, ready, cur_track
   );
endinterface

// File: rtl/multi_drive_ctrl.sv
// Multi-drive floppy controller: select decode, rate-limited 4-phase steppers, spindle gating, spin-up and index stretch.
// Inputs pass a 2-FF sync (+1 cycle for step edges); STEP_QUEUE_EN queues steps that arrive mid-step instead of dropping them.
module multi_drive_ctrl #(
   parameter int NUM_DRIVES    = 2,
   parameter int MAX_TRACK     = 79,
   parameter int STEP_CYCLES   = 144000,
   parameter int HOLD_CYCLES   = 960000,
   parameter int SPINUP_CYCLES = 24000000,
   parameter int INDEX_CYCLES  = 192
) (
   input  logic                    clk,
   input  logic                    rst,
   multi_drive_ctrl_if.slave       fdc,
   input  logic [NUM_DRIVES-1:0]   ind_sens,
   input  logic [NUM_DRIVES-1:0]   t00_sens,
   input  logic [NUM_DRIVES-1:0]   wpr_sens,
   input  logic [NUM_DRIVES-1:0]   dsk_sens,
   output logic [4*NUM_DRIVES-1:0] step_drv,
   output logic [NUM_DRIVES-1:0]   spin_en,
   output logic [NUM_DRIVES-1:0]   spin_ss,
   output logic [NUM_DRIVES-1:0]   dsk_LED
);
   localparam int TMAX = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int UW   = $clog2(SPINUP_CYCLES + 1);
   localparam int IW   = $clog2(INDEX_CYCLES + 1);
   localparam int SW   = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;
   localparam int YW   = 5 * NUM_DRIVES + 4;

   // Synchroniser idles with active-low controls released and sensors inactive.
   localparam logic [YW-1:0] SYNC_RST = {{NUM_DRIVES{1'b1}}, 4'b1010, {(4 * NUM_DRIVES){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STEP,
      ST_HOLD
   } step_state_e;

   function automatic logic [3:0] coil_of(input logic [1:0] p);
      logic [3:0] c;
      c = 4'b0011;
      case (p)
         2'd0: c = 4'b0011;
         2'd1: c = 4'b0110;
         2'd2: c = 4'b1100;
         2'd3: c = 4'b1001;
         default: c = 4'b0011;
      endcase
      return c;
   endfunction

   logic [YW-1:0]         sync_in;
   logic [YW-1:0]         meta_q, meta_d;
   logic [YW-1:0]         sync_q, sync_d;

   logic [NUM_DRIVES-1:0] drive_sel_s;
   logic                  motor_on_s;
   logic                  dir_s;
   logic                  step_s;
   logic                  dens_s;
   logic [NUM_DRIVES-1:0] ind_s;
   logic [NUM_DRIVES-1:0] t00_s;
   logic [NUM_DRIVES-1:0] wpr_s;
   logic [NUM_DRIVES-1:0] dsk_s;

   logic                  step_prev_q, step_prev_d;
   logic [NUM_DRIVES-1:0] ind_prev_q, ind_prev_d;
   logic                  step_edge;

   logic                  sel_vld;
   logic [SW-1:0]         sel_idx;

   step_state_e           state_q    [NUM_DRIVES];
   step_state_e           state_d    [NUM_DRIVES];
   logic [1:0]            phase_q    [NUM_DRIVES];
   logic [1:0]            phase_d    [NUM_DRIVES];
   logic [6:0]            track_q    [NUM_DRIVES];
   logic [6:0]            track_d    [NUM_DRIVES];
   logic [TW-1:0]         timer_q    [NUM_DRIVES];
   logic [TW-1:0]         timer_d    [NUM_DRIVES];
   logic [UW-1:0]         spin_cnt_q [NUM_DRIVES];
   logic [UW-1:0]         spin_cnt_d [NUM_DRIVES];
   logic [IW-1:0]         idx_cnt_q  [NUM_DRIVES];
   logic [IW-1:0]         idx_cnt_d  [NUM_DRIVES];

   logic [NUM_DRIVES-1:0] spin_en_q, spin_en_d;
   logic [NUM_DRIVES-1:0] spin_ss_q, spin_ss_d;
   logic [NUM_DRIVES-1:0] led_q, led_d;

`ifdef STEP_QUEUE_EN
   logic [2:0]            q_cnt_q    [NUM_DRIVES];
   logic [2:0]            q_cnt_d    [NUM_DRIVES];
   logic [NUM_DRIVES-1:0] q_dir_q, q_dir_d;
`endif

   assign sync_in = {fdc.drive_sel, fdc.motor_on, fdc.dir_sel, fdc.step, fdc.dens_sel,
                     ind_sens, t00_sens, wpr_sens, dsk_sens};
   assign {drive_sel_s, motor_on_s, dir_s, step_s, dens_s, ind_s, t00_s, wpr_s, dsk_s} = sync_q;

   always_comb begin
      meta_d      = sync_in;
      sync_d      = meta_q;
      step_prev_d = step_s;
      ind_prev_d  = ind_s;
   end

   assign step_edge = step_prev_q & ~step_s;

   // Descending scan so the lowest active select wins.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      for (int n = NUM_DRIVES - 1; n >= 0; n--) begin
         if (!drive_sel_s[n]) begin
            sel_vld = 1'b1;
            sel_idx = SW'(n);
         end
      end
   end

   always_comb begin
      logic req;
      logic try_step;
      logic try_dir;
      logic blocked;
`ifdef STEP_QUEUE_EN
      logic [2:0] qm;
      logic       qdm;
      q_dir_d = q_dir_q;
`endif
      for (int n = 0; n < NUM_DRIVES; n++) begin
         state_d[n] = state_q[n];
         phase_d[n] = phase_q[n];
         track_d[n] = track_q[n];
         timer_d[n] = timer_q[n];
`ifdef STEP_QUEUE_EN
         q_cnt_d[n] = q_cnt_q[n];
         qm         = q_cnt_q[n];
         qdm        = q_dir_q[n];
`endif
         req      = step_edge && sel_vld && (sel_idx == SW'(n));
         try_step = 1'b0;
         try_dir  = dir_s;

         case (state_q[n])
            ST_IDLE: begin
               try_step = req;
            end
            ST_HOLD: begin
               if (timer_q[n] == '0) begin
                  state_d[n] = ST_IDLE;
               end else begin
                  timer_d[n] = timer_q[n] - TW'(1);
               end
               try_step = req;
            end
            ST_STEP: begin
`ifdef STEP_QUEUE_EN
               // A direction reversal discards older pending steps.
               if (req) begin
                  if (qm == 3'd0 || qdm != dir_s) begin
                     qm  = 3'd1;
                     qdm = dir_s;
                  end else if (qm != 3'd7) begin
                     qm = qm + 3'd1;
                  end
               end
               q_cnt_d[n] = qm;
               q_dir_d[n] = qdm;
`endif
               if (timer_q[n] == '0) begin
                  state_d[n] = ST_HOLD;
                  timer_d[n] = TW'(HOLD_CYCLES - 1);
`ifdef STEP_QUEUE_EN
                  if (qm != 3'd0) begin
                     try_step   = 1'b1;
                     try_dir    = qdm;
                     q_cnt_d[n] = qm - 3'd1;
                  end
`endif
               end else begin
                  timer_d[n] = timer_q[n] - TW'(1);
               end
            end
            default: begin
               state_d[n] = ST_IDLE;
            end
         endcase

         blocked = try_dir ? t00_s[n] : (track_q[n] == 7'(MAX_TRACK));
         if (try_step && !blocked) begin
            state_d[n] = ST_STEP;
            timer_d[n] = TW'(STEP_CYCLES - 1);
            if (try_dir) begin
               phase_d[n] = phase_q[n] - 2'd1;
               if (track_q[n] != 7'd0) begin
                  track_d[n] = track_q[n] - 7'd1;
               end
            end else begin
               phase_d[n] = phase_q[n] + 2'd1;
               track_d[n] = track_q[n] + 7'd1;
            end
         end

         if (t00_s[n]) begin
            track_d[n] = '0;
         end
      end
   end

   always_comb begin
      spin_en_d = {NUM_DRIVES{~motor_on_s}} & dsk_s;
      spin_ss_d = {NUM_DRIVES{dens_s}};
      led_d     = dsk_s;
      for (int n = 0; n < NUM_DRIVES; n++) begin
         spin_cnt_d[n] = spin_cnt_q[n];
         if (!spin_en_q[n]) begin
            spin_cnt_d[n] = '0;
         end else if (spin_cnt_q[n] != UW'(SPINUP_CYCLES)) begin
            spin_cnt_d[n] = spin_cnt_q[n] + UW'(1);
         end

         idx_cnt_d[n] = idx_cnt_q[n];
         if (ind_s[n] && !ind_prev_q[n]) begin
            idx_cnt_d[n] = IW'(INDEX_CYCLES);
         end else if (idx_cnt_q[n] != '0) begin
            idx_cnt_d[n] = idx_cnt_q[n] - IW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q      <= SYNC_RST;
         sync_q      <= SYNC_RST;
         step_prev_q <= 1'b1;
         ind_prev_q  <= '0;
         spin_en_q   <= '0;
         spin_ss_q   <= '0;
         led_q       <= '0;
`ifdef STEP_QUEUE_EN
         q_dir_q     <= '0;
`endif
         for (int n = 0; n < NUM_DRIVES; n++) begin
            state_q[n]    <= ST_IDLE;
            phase_q[n]    <= '0;
            track_q[n]    <= '0;
            timer_q[n]    <= '0;
            spin_cnt_q[n] <= '0;
            idx_cnt_q[n]  <= '0;
`ifdef STEP_QUEUE_EN
            q_cnt_q[n]    <= '0;
`endif
         end
      end else begin
         meta_q      <= meta_d;
         sync_q      <= sync_d;
         step_prev_q <= step_prev_d;
         ind_prev_q  <= ind_prev_d;
         spin_en_q   <= spin_en_d;
         spin_ss_q   <= spin_ss_d;
         led_q       <= led_d;
`ifdef STEP_QUEUE_EN
         q_dir_q     <= q_dir_d;
`endif
         for (int n = 0; n < NUM_DRIVES; n++) begin
            state_q[n]    <= state_d[n];
            phase_q[n]    <= phase_d[n];
            track_q[n]    <= track_d[n];
            timer_q[n]    <= timer_d[n];
            spin_cnt_q[n] <= spin_cnt_d[n];
            idx_cnt_q[n]  <= idx_cnt_d[n];
`ifdef STEP_QUEUE_EN
            q_cnt_q[n]    <= q_cnt_d[n];
`endif
         end
      end
   end

   always_comb begin
      step_drv = '0;
      for (int n = 0; n < NUM_DRIVES; n++) begin
         if (state_q[n] != ST_IDLE) begin
            step_drv[4*n +: 4] = coil_of(phase_q[n]);
         end
      end
   end

   assign spin_en = spin_en_q;
   assign spin_ss = spin_ss_q;
   assign dsk_LED = led_q;

   always_comb begin
      logic rdy_n;
      rdy_n          = 1'b1;
      fdc.index      = 1'b1;
      fdc.track_0    = 1'b1;
      fdc.wr_protect = 1'b1;
      fdc.cur_track  = '0;
      if (sel_vld) begin
         rdy_n          = !(spin_cnt_q[sel_idx] == UW'(SPINUP_CYCLES));
         fdc.index      = !((idx_cnt_q[sel_idx] != '0) && !rdy_n);
         fdc.track_0    = !t00_s[sel_idx];
         fdc.wr_protect = !(wpr_s[sel_idx] || !dsk_s[sel_idx]);
         fdc.cur_track  = track_q[sel_idx];
      end
      fdc.ready = rdy_n;
   end
endmodule

// File: tb/tb_multi_drive_ctrl.sv
// Directed bench for multi_drive_ctrl with shortened step/hold/spin-up timing.
module tb_multi_drive_ctrl;
   localparam int N = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   ind_sens = '0;
   logic [N-1:0]   t00_sens = '0;
   logic [N-1:0]   wpr_sens = '0;
   logic [N-1:0]   dsk_sens = '0;
   logic [4*N-1:0] step_drv;
   logic [N-1:0]   spin_en;
   logic [N-1:0]   spin_ss;
   logic [N-1:0]   dsk_LED;

   multi_drive_ctrl_if #(.NUM_DRIVES(N)) fdc ();

   multi_drive_ctrl #(
      .NUM_DRIVES(N), .MAX_TRACK(79), .STEP_CYCLES(40), .HOLD_CYCLES(100),
      .SPINUP_CYCLES(100), .INDEX_CYCLES(192)
   ) dut (
      .clk(clk), .rst(rst), .fdc(fdc),
      .ind_sens(ind_sens), .t00_sens(t00_sens), .wpr_sens(wpr_sens), .dsk_sens(dsk_sens),
      .step_drv(step_drv), .spin_en(spin_en), .spin_ss(spin_ss), .dsk_LED(dsk_LED)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int ph  = 0;
   int trk = 0;
   logic [3:0] coils [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};

   typedef struct {
      logic [1:0] sel;
      logic [1:0] t00;
      logic [1:0] wpr;
      logic [1:0] dsk;
      logic       dens;
      logic       t0;
      logic       wp;
      logic [1:0] led;
   } vec_t;
   vec_t vt [7];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse(input logic dir);
      fdc.dir_sel = dir;
      fdc.step    = 1'b0;
      tick(3);
      fdc.step    = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{2'b10, 2'b01, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 2'b11};
      vt[1] = '{2'b10, 2'b10, 2'b01, 2'b11, 1'b1, 1'b1, 1'b0, 2'b11};
      vt[2] = '{2'b01, 2'b10, 2'b01, 2'b11, 1'b0, 1'b0, 1'b1, 2'b11};
      vt[3] = '{2'b00, 2'b10, 2'b10, 2'b01, 1'b1, 1'b1, 1'b1, 2'b01};
      vt[4] = '{2'b00, 2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 2'b10};
      vt[5] = '{2'b11, 2'b11, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00};
      vt[6] = '{2'b01, 2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 1'b1, 2'b10};

      fdc.drive_sel = 2'b10;
      fdc.motor_on  = 1'b1;
      fdc.dir_sel   = 1'b0;
      fdc.step      = 1'b1;
      fdc.dens_sel  = 1'b0;
      tick(3);
      chk("rst_step_drv",   32'(step_drv),       32'h0);
      chk("rst_index",      32'(fdc.index),      32'h1);
      chk("rst_track_0",    32'(fdc.track_0),    32'h1);
      chk("rst_wr_protect", 32'(fdc.wr_protect), 32'h1);
      chk("rst_ready",      32'(fdc.ready),      32'h1);
      chk("rst_cur_track",  32'(fdc.cur_track),  32'h0);
      chk("rst_spin_en",    32'(spin_en),        32'h0);
      chk("rst_dsk_LED",    32'(dsk_LED),        32'h0);
      rst = 1'b0;

      // Select decode and status mapping
      for (int i = 0; i < 7; i++) begin
         fdc.drive_sel = vt[i].sel;
         t00_sens      = vt[i].t00;
         wpr_sens      = vt[i].wpr;
         dsk_sens      = vt[i].dsk;
         fdc.dens_sel  = vt[i].dens;
         tick(3);
         chk($sformatf("vec%0d_track_0", i),    32'(fdc.track_0),    32'(vt[i].t0));
         chk($sformatf("vec%0d_wr_protect", i), 32'(fdc.wr_protect), 32'(vt[i].wp));
         chk($sformatf("vec%0d_dsk_LED", i),    32'(dsk_LED),        32'(vt[i].led));
         chk($sformatf("vec%0d_spin_ss", i),    32'(spin_ss),        32'({2{vt[i].dens}}));
         chk($sformatf("vec%0d_ready", i),      32'(fdc.ready),      32'h1);
      end

      fdc.drive_sel = 2'b10;
      t00_sens = '0;
      wpr_sens = '0;
      dsk_sens = '0;
      tick(3);

      // Three inward steps, 50 cycles apart
      for (int i = 0; i < 3; i++) begin
         if (i > 0) tick(47);
         pulse(1'b0);
         ph++;
         trk++;
         chk($sformatf("stepA%0d_coils", i), 32'(step_drv[3:0]), 32'(coils[ph & 3]));
         chk($sformatf("stepA%0d_track", i), 32'(fdc.cur_track), 32'(trk));
      end
      tick(139);
      chk("hold_coils_on",   32'(step_drv[3:0]), 32'(coils[ph & 3]));
      tick(1);
      chk("hold_coils_off",  32'(step_drv[3:0]), 32'h0);

      // Second step 10 cycles after the first: dropped or queued
      pulse(1'b0);
      ph++;
      trk++;
      chk("stepB0_coils", 32'(step_drv[3:0]), 32'(coils[ph & 3]));
      tick(7);
      pulse(1'b0);
      chk("stepB1_track_early", 32'(fdc.cur_track), 32'(trk));
      tick(29);
      chk("stepB1_track_e39", 32'(fdc.cur_track), 32'(trk));
      tick(1);
`ifdef STEP_QUEUE_EN
      ph++;
      trk++;
`endif
      chk("stepB1_track_e40", 32'(fdc.cur_track), 32'(trk));
      chk("stepB1_coils_e40", 32'(step_drv[3:0]), 32'(coils[ph & 3]));
      tick(160);

      // Outward step blocked by the track-0 sensor during HOLD
      pulse(1'b0);
      ph++;
      trk++;
      tick(42);
      t00_sens = 2'b01;
      pulse(1'b1);
      trk = 0;
      chk("t00_track",   32'(fdc.cur_track), 32'h0);
      chk("t00_coils",   32'(step_drv[3:0]), 32'(coils[ph & 3]));
      chk("t00_track_0", 32'(fdc.track_0),   32'h0);
      t00_sens = '0;
      tick(3);

      // Climb to MAX_TRACK, then try one more inward step
      for (int i = 0; i < 79; i++) begin
         pulse(1'b0);
         ph++;
         trk++;
         tick(42);
      end
      chk("max_track_reached", 32'(fdc.cur_track), 32'd79);
      pulse(1'b0);
      chk("max_track_hold",  32'(fdc.cur_track), 32'd79);
      chk("max_track_coils", 32'(step_drv[3:0]), 32'(coils[ph & 3]));
      tick(5);
      pulse(1'b1);
      ph--;
      trk--;
      chk("outward_track", 32'(fdc.cur_track), 32'(trk));
      chk("outward_coils", 32'(step_drv[3:0]), 32'(coils[ph & 3]));

      // Drive 1: spindle, spin-up, index stretch, deselect
      fdc.drive_sel = 2'b01;
      fdc.motor_on  = 1'b0;
      dsk_sens      = 2'b10;
      tick(2);
      chk("spin_en_c2", 32'(spin_en), 32'h0);
      tick(1);
      chk("spin_en_c3", 32'(spin_en), 32'h2);
      chk("led_c3",     32'(dsk_LED), 32'h2);
      tick(99);
      chk("ready_c99",  32'(fdc.ready), 32'h1);
      tick(1);
      chk("ready_c100", 32'(fdc.ready), 32'h0);
      chk("index_idle", 32'(fdc.index), 32'h1);
      ind_sens = 2'b10;
      tick(2);
      chk("index_c2",   32'(fdc.index), 32'h1);
      tick(1);
      chk("index_c3",   32'(fdc.index), 32'h0);
      ind_sens = '0;
      tick(191);
      chk("index_last", 32'(fdc.index), 32'h0);
      tick(1);
      chk("index_end",  32'(fdc.index), 32'h1);
      ind_sens = 2'b10;
      t00_sens = 2'b10;
      wpr_sens = 2'b10;
      tick(3);
      chk("sel1_index",      32'(fdc.index),      32'h0);
      chk("sel1_track_0",    32'(fdc.track_0),    32'h0);
      chk("sel1_wr_protect", 32'(fdc.wr_protect), 32'h0);
      ind_sens = '0;
      fdc.drive_sel = 2'b11;
      tick(2);
      chk("desel_index",      32'(fdc.index),      32'h1);
      chk("desel_ready",      32'(fdc.ready),      32'h1);
      chk("desel_track_0",    32'(fdc.track_0),    32'h1);
      chk("desel_wr_protect", 32'(fdc.wr_protect), 32'h1);
      chk("desel_cur_track",  32'(fdc.cur_track),  32'h0);

      // Select and step edge synchronised together; then reset mid-step
      fdc.motor_on = 1'b1;
      t00_sens = '0;
      wpr_sens = '0;
      tick(3);
      fdc.drive_sel = 2'b10;
      pulse(1'b0);
      ph++;
      trk++;
      chk("simul_coils0", 32'(step_drv[3:0]), 32'(coils[ph & 3]));
      chk("simul_coils1", 32'(step_drv[7:4]), 32'h0);
      chk("simul_track",  32'(fdc.cur_track), 32'(trk));
      tick(5);
      rst = 1'b1;
      tick(1);
      chk("midrst_step_drv", 32'(step_drv), 32'h0);
      rst = 1'b0;
      tick(3);
      chk("postrst_track",    32'(fdc.cur_track), 32'h0);
      chk("postrst_step_drv", 32'(step_drv),      32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/multi_drive_ctrl.md
Name: multi_drive_ctrl

Overview:
- Parametrised successor to the single-drive control circuit. Serves NUM_DRIVES floppy mechanisms from one shared Shugart-style FDC bus.
- Per drive: decodes drive select, runs a rate-limited 4-phase stepper sequencer with a track counter, gates the spindle, and times spin-up.
- Stretches index pulses and drives the shared active-low status lines back to the FDC.
- Sits between the FDC breakout pins and the per-drive ULN2003 / spindle drivers.

Parameters:
NUM_DRIVES, 2, number of mechanisms served (1..4)
MAX_TRACK, 79, highest legal track number
STEP_CYCLES, 144000, minimum clk cycles between executed steps (3 ms at 48 MHz)
HOLD_CYCLES, 960000, idle cycles after last step before coils de-energise
SPINUP_CYCLES, 24000000, cycles from spin_en to ready
INDEX_CYCLES, 192, index pulse stretch length (4 us)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
drive_sel  in  NUM_DRIVES  FDC drive selects, active-low, one bit per drive
motor_on  in  1  FDC motor request, active-low
dir_sel  in  1  step direction: 0 = inward (track+1), 1 = outward
step  in  1  FDC step, active-low; a falling edge requests one step
dens_sel  in  1  density select, passed to spin_ss
ind_sens  in  NUM_DRIVES  index sensors, active-high
t00_sens  in  NUM_DRIVES  track-0 sensors, active-high
wpr_sens  in  NUM_DRIVES  write-protect sensors, active-high
dsk_sens  in  NUM_DRIVES  disk-present sensors, active-high
step_drv  out  4*NUM_DRIVES  coil drives; drive n uses bits [4n+3:4n]
spin_en  out  NUM_DRIVES  spindle enable per drive
spin_ss  out  NUM_DRIVES  spindle speed select per drive
dsk_LED  out  NUM_DRIVES  disk-present LED per drive
index  out  1  FDC index, active-low
track_0  out  1  FDC track 0, active-low
wr_protect  out  1  FDC write protect, active-low
ready  out  1  FDC ready, active-low
cur_track  out  7  track counter of the selected drive (debug); 0 when none is selected

Behaviour:
- All FDC inputs and sensor inputs pass through a 2-FF synchroniser; all logic uses the synchronised values. Step edge detection adds 1 more cycle.
- Selected drive = lowest index n with drive_sel[n] = 0. If no drive is selected: the four FDC status outputs are 1, cur_track = 0, and steps are ignored.
- Reset values:
  - step_drv all 0; phase indices 0; track counters 0.
  - spin_en, spin_ss, dsk_LED all 0.
  - index, track_0, wr_protect, ready all 1.
  - All timers cleared; queue empty.
- Per-drive stepper FSM, states IDLE, STEP, HOLD:
  - Phase sequence p0..p3 = 0011, 0110, 1100, 1001.
  - IDLE: coils 0000.
  - A step edge while the drive is selected and in IDLE or HOLD executes a step; the next cycle enters STEP with the busy timer loaded to STEP_CYCLES-1.
  - Inward: phase+1 mod 4, track+1. Outward: phase-1 mod 4, track-1.
  - STEP: coils = current phase; timer counts down; at 0 the FSM enters HOLD with the hold timer loaded to HOLD_CYCLES-1.
  - HOLD: coils = current phase; timer expiry goes to IDLE. A step in HOLD executes immediately.
  - A step edge arriving in STEP is dropped (see Optional Feature).
- Boundaries:
  - Outward step while t00_sens = 1: no phase or track change, no timer start.
  - Inward step at MAX_TRACK: ignored.
  - t00_sens = 1 forces the track counter to 0 every cycle (recalibration).
  - Track counter never wraps.
- Spindle and LED:
  - spin_en[n] = (motor_on = 0) AND dsk_sens[n], registered.
  - spin_ss[n] = dens_sel, registered.
  - dsk_LED[n] = dsk_sens[n], registered.
- Spin-up timer (per drive): clears while spin_en[n] = 0; counts while spin_en[n] = 1, saturating at SPINUP_CYCLES. ready = 0 when the selected drive's timer is saturated.
- Index stretch: a rising edge of ind_sens[n] loads the stretch counter to INDEX_CYCLES. index = 0 while the selected drive's counter is non-zero and ready = 0. A new edge during a stretch reloads the counter.
- track_0 = NOT t00_sens[sel]; wr_protect = NOT (wpr_sens[sel] OR NOT dsk_sens[sel]).
- Simultaneous step edge and drive-select change: the select value synchronised in the same cycle as the edge decides the target drive.
- rst asserted mid-step returns every FSM to IDLE with coils 0000 on the next cycle. Track counters return to 0; the host must recalibrate.

Optional Feature:
- Macro STEP_QUEUE_EN.
- Defined: per-drive 3-bit pending-step counter (saturates at 7) with a stored direction. A step edge during STEP increments the counter. A step edge with a different direction flushes the counter to 1 with the new direction. On STEP timer expiry with a non-zero counter, the FSM executes the next step directly (STEP to STEP) and decrements the counter.
- Undefined: edges during STEP are dropped and no counter exists.

Test Plan:
- Reset with drive 0 selected, motor_on=1 -> step_drv=0, index/track_0/wr_protect/ready = 1, cur_track=0.
- Select drive 0, three inward steps 4 ms apart (STEP_CYCLES=144000) -> step_drv[3:0] = 0110, 1100, 1001; cur_track=3; coils go to 0000 HOLD_CYCLES after the last STEP timer expiry.
- Two inward steps 1 ms apart -> without STEP_QUEUE_EN cur_track=1; with it cur_track=2, second step executed exactly STEP_CYCLES after the first.
- At track 1, t00_sens[0]=1, step outward -> cur_track=0, coils unchanged, track_0=0; with track already at MAX_TRACK=79, an inward step leaves 79.
- dsk_sens[1]=1, select drive 1, motor_on=0 (SPINUP_CYCLES=100) -> spin_en[1]=1 after 3 cycles; ready=0 100 cycles later; an ind_sens pulse gives index=0 for exactly 192 cycles; deselecting drive 1 -> all status lines 1.
